// File: rtl/cache_read_arbiter_pkg.sv
// Shared cache definitions: arbiter FSM states, requester source codes and burst lengths.
// Used by the read arbiter and its priority selector.
package cache_read_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2
  } cra_state_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_INST = 2'd1,
    SRC_DATA = 2'd2,
    SRC_DUC  = 2'd3
  } cra_src_e;

  localparam logic [3:0] LEN_LINE = 4'h7;
  localparam logic [3:0] LEN_WORD = 4'h0;

  // Data refills and cached instruction fetches move a whole line; everything else is one word.
  function automatic logic [3:0] burst_len(input cra_src_e src, input logic inst_uncached);
    logic [3:0] len;
    case (src)
      SRC_DATA: len = LEN_LINE;
      SRC_INST: len = inst_uncached ? LEN_WORD : LEN_LINE;
      default:  len = LEN_WORD;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/cra_select.sv
// Combinational owner selection: fixed priority duc > data > inst, with instruction
// fetch promoted once it has been passed over AGE_LIMIT times.
module cra_select
  import cache_read_arbiter_pkg::*;
#(
  parameter int AGE_LIMIT = 4
) (
  input  logic       inst_req,
  input  logic       data_req,
  input  logic       duc_req,
  input  logic [2:0] age_cnt,
  output cra_src_e   src
);

  // Priority pick with the aging override checked first.
  always_comb begin
    src = SRC_NONE;
    if (inst_req && (age_cnt == 3'(AGE_LIMIT))) begin
      src = SRC_INST;
    end else if (duc_req) begin
      src = SRC_DUC;
    end else if (data_req) begin
      src = SRC_DATA;
    end else if (inst_req) begin
      src = SRC_INST;
    end else begin
      src = SRC_NONE;
    end
  end

endmodule

// File: rtl/cache_read_arbiter.sv
// Read arbiter sharing one downstream read port between ICache, DCache refill and
// D-uncached requesters; one transaction in flight, owner latched at grant.
module cache_read_arbiter
  import cache_read_arbiter_pkg::*;
#(
  parameter int AGE_LIMIT = 4,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  input  logic              inst_uncached_i,
  input  logic              data_req_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic              duc_req_i,
  input  logic [ADDR_W-1:0] duc_addr_i,
  output logic              inst_done_o,
  output logic              data_done_o,
  output logic              duc_done_o,
  output logic              req_valid_o,
  input  logic              req_ready_i,
  output logic [ADDR_W-1:0] req_addr_o,
  output logic [3:0]        req_len_o,
  output logic [1:0]        req_src_o,
  input  logic              done_i
);

  cra_state_e        state_r, state_s;
  cra_src_e          src_r, sel_src_s;
  logic [ADDR_W-1:0] addr_r, raw_addr_s, sel_addr_s;
  logic [3:0]        len_r, sel_len_s;
  logic [2:0]        age_r, age_s;
  logic              valid_r, inst_done_r, data_done_r, duc_done_r;
  logic              grant_s, finish_s;

  // A requester whose done pulse is high is being released and must not be re-granted.
  cra_select #(.AGE_LIMIT(AGE_LIMIT)) u_select (
    .inst_req (inst_req_i & ~inst_done_r),
    .data_req (data_req_i & ~data_done_r),
    .duc_req  (duc_req_i & ~duc_done_r),
    .age_cnt  (age_r),
    .src      (sel_src_s)
  );

  assign grant_s  = (state_r == ST_IDLE) && (sel_src_s != SRC_NONE);
  assign finish_s = (state_r == ST_BUSY) && done_i;

  // Next-state logic; done_i only matters in BUSY.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:  if (grant_s) state_s = ST_ISSUE; else state_s = ST_IDLE;
      ST_ISSUE: if (req_ready_i) state_s = ST_BUSY; else state_s = ST_ISSUE;
      ST_BUSY:  if (done_i) state_s = ST_IDLE; else state_s = ST_BUSY;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Raw address of the selected requester.
  always_comb begin
    raw_addr_s = {ADDR_W{1'b0}};
    case (sel_src_s)
      SRC_INST: raw_addr_s = inst_addr_i;
      SRC_DATA: raw_addr_s = data_addr_i;
      SRC_DUC:  raw_addr_s = duc_addr_i;
      default:  raw_addr_s = {ADDR_W{1'b0}};
    endcase
  end

  assign sel_len_s  = burst_len(sel_src_s, inst_uncached_i);
  assign sel_addr_s = (sel_len_s == LEN_LINE) ? {raw_addr_s[ADDR_W-1:5], 5'b00000} : raw_addr_s;

  // Starvation counter for instruction fetch, saturating at AGE_LIMIT.
  always_comb begin
    age_s = age_r;
    if (!inst_req_i) begin
      age_s = 3'd0;
    end else if (grant_s && (sel_src_s == SRC_INST)) begin
      age_s = 3'd0;
    end else if (grant_s && (age_r != 3'(AGE_LIMIT))) begin
      age_s = age_r + 3'd1;
    end else begin
      age_s = age_r;
    end
  end

  // State, latched request and registered completion pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      src_r       <= SRC_NONE;
      addr_r      <= {ADDR_W{1'b0}};
      len_r       <= 4'h0;
      valid_r     <= 1'b0;
      age_r       <= 3'd0;
      inst_done_r <= 1'b0;
      data_done_r <= 1'b0;
      duc_done_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      valid_r     <= (state_s == ST_ISSUE);
      age_r       <= age_s;
      inst_done_r <= finish_s && (src_r == SRC_INST);
      data_done_r <= finish_s && (src_r == SRC_DATA);
      duc_done_r  <= finish_s && (src_r == SRC_DUC);
      if (grant_s) begin
        src_r  <= sel_src_s;
        addr_r <= sel_addr_s;
        len_r  <= sel_len_s;
      end
    end
  end

  assign req_valid_o = valid_r;
  assign req_addr_o  = addr_r;
  assign req_len_o   = len_r;
  assign req_src_o   = src_r;
  assign inst_done_o = inst_done_r;
  assign data_done_o = data_done_r;
  assign duc_done_o  = duc_done_r;

endmodule

// File: doc/cache_read_arbiter.md
CACHE_READ_ARBITER -- requirements
Module: cache_read_arbiter

Interface
REQ-001 Parameter AGE_LIMIT, default 4, range 1..7: consecutive non-instruction grants tolerated while inst_req_i is pending.
REQ-002 Parameter ADDR_W, default 32: address width.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 inst_req_i  input  1  ICache read request, held until inst_done_o.
REQ-006 inst_addr_i  input  ADDR_W  ICache request address.
REQ-007 inst_uncached_i  input  1  ICache request is a single-word uncached read.
REQ-008 data_req_i  input  1  DCache line-refill request, held until data_done_o.
REQ-009 data_addr_i  input  ADDR_W  DCache refill address.
REQ-010 duc_req_i  input  1  D-uncached single-word read request, held until duc_done_o.
REQ-011 duc_addr_i  input  ADDR_W  D-uncached address.
REQ-012 inst_done_o, data_done_o, duc_done_o  output  1 each  one-cycle completion pulse to the owning requester.
REQ-013 req_valid_o  output  1  downstream read request valid.
REQ-014 req_ready_i  input  1  downstream accepts request.
REQ-015 req_addr_o  output  ADDR_W  registered request address.
REQ-016 req_len_o  output  4  burst length minus one: 4'h7 for a cached line, 4'h0 for uncached.
REQ-017 req_src_o  output  2  owner: 2'd0 none, 2'd1 inst, 2'd2 data, 2'd3 duc.
REQ-018 done_i  input  1  downstream pulse: final beat of the current transaction returned.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE and BUSY.
- IDLE->ISSUE when any unmasked request is present.
- ISSUE->BUSY when req_ready_i=1.
- BUSY->IDLE when done_i=1.
REQ-020 In IDLE the arbiter SHALL select the owner with fixed priority duc > data > inst, except that inst wins when age_cnt == AGE_LIMIT.
REQ-021 On the IDLE->ISSUE edge, the selected address and length SHALL be latched into req_addr_o, req_len_o and req_src_o. These outputs SHALL remain stable until the next grant.
REQ-022 Address formation:
- Cached line (data, or inst with inst_uncached_i=0): req_addr_o = {addr[ADDR_W-1:5],5'b0}.
- Uncached: the address is passed unmodified.
REQ-023 req_valid_o SHALL be 1 exactly while in ISSUE; request-to-req_valid_o latency is one cycle.
REQ-024 The owner's done pulse SHALL be registered: asserted the cycle after done_i, together with entry to IDLE.
REQ-025 In the IDLE cycle where a done_o pulse is high, that requester SHALL be masked from arbitration. This prevents a re-grant of a request that is being released.
REQ-026 age_cnt (3 bits) behaviour:
- Increments on each grant to data or duc while inst_req_i=1.
- Saturates at AGE_LIMIT.
- Clears on an inst grant, or in any cycle where inst_req_i=0.
REQ-027 Request inputs sampled outside IDLE SHALL be ignored; grants are never pre-empted.
REQ-028 done_i arriving in IDLE or ISSUE SHALL be ignored.
REQ-029 If done_i and req_ready_i are both high in ISSUE, only the ISSUE->BUSY transition SHALL occur.
REQ-030 A requester dropping its request while owning the transaction SHALL NOT abort it; the done pulse is still issued.

Reset
REQ-031 On rst the block SHALL return to IDLE, whatever its state, including mid-transaction. Outputs after reset:
- req_valid_o=0, req_addr_o=0, req_len_o=0, req_src_o=0.
- All done_o=0.
- age_cnt=0.
REQ-032 The first arbitration after reset SHALL occur in the first cycle with rst=0.

Structure
REQ-033 The FSM state encodings, the req_src codes, and the LEN_LINE=4'h7 and LEN_WORD=4'h0 constants SHALL reside in the shared cache defines package.
REQ-034 The priority/aging selection SHALL be one combinational sub-module, cra_select.

Verification
REQ-035 duc_req_i, data_req_i and inst_req_i all asserted in the same cycle -> req_src_o=3 first, then 2, then 1; the inst grant is third.
REQ-036 inst_req_i=1, inst_addr_i=32'h1FC0_0014, inst_uncached_i=0, req_ready_i=1 immediately -> req_addr_o=32'h1FC0_0000, req_len_o=7. inst_done_o pulses one cycle after done_i.
REQ-037 duc_req_i=1, duc_addr_i=32'hBFAF_8004 -> req_addr_o=32'hBFAF_8004, req_len_o=0.
REQ-038 AGE_LIMIT=2; inst_req_i held while data_req_i is re-asserted continuously -> data, data, inst, data.
REQ-039 Assert rst during BUSY -> next cycle req_valid_o=0, req_src_o=0, and no done pulse; a later done_i is ignored.
REQ-040 Requester still holding its request in the done_o cycle, with no other requests -> no re-grant in that cycle; grant issued in the following cycle.
